// File: rtl/bus_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bus_load_sequencer
// Description : Turns queued destination-write requests into one-hot,
//               single-cycle register load strobes with aligned load data.
//               A HI pair request also writes LO on the following cycle.
//               Optional macro R0_WRITE_GUARD_EN: when defined, requests to
//               destination 0 are consumed without strobing load_en[0].
// Revision    : 1.0 - initial release
// ============================================================================
module bus_load_sequencer #(
  parameter int NUM_DEST = 25,
  parameter int DEPTH    = 2,
  parameter int DATA_W   = 32
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_dest,
  input  logic                req_pair,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [DATA_W-1:0]   req_data2,
  output logic [NUM_DEST-1:0] load_en,
  output logic [DATA_W-1:0]   load_data,
  output logic                busy,
  output logic                bad_dest,
  output logic [4:0]          bad_code
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]    c_full_count = CNT_W'(DEPTH);
  localparam logic [4:0]          c_dest_hi    = 5'd16;
  localparam logic [NUM_DEST-1:0] c_lo_onehot  = NUM_DEST'(1) << 17;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  // Request FIFO storage
  logic [4:0]        r_mem_dest  [DEPTH];
  logic              r_mem_pair  [DEPTH];
  logic [DATA_W-1:0] r_mem_data  [DEPTH];
  logic [DATA_W-1:0] r_mem_data2 [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Sequencer state and registered outputs
  state_t              r_state;
  logic [DATA_W-1:0]   r_pair_data;
  logic [NUM_DEST-1:0] r_load_en;
  logic [DATA_W-1:0]   r_load_data;
  logic                r_bad_dest;
  logic [4:0]          r_bad_code;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [4:0]          w_head_dest;
  logic                w_head_pair;
  logic [DATA_W-1:0]   w_head_data;
  logic [DATA_W-1:0]   w_head_data2;
  logic                w_head_in_range;
  logic                w_head_guarded;
  logic                w_head_strobe;
  logic [NUM_DEST-1:0] w_head_onehot;

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign w_full    = (r_count == c_full_count);
  assign w_empty   = (r_count == '0);
  assign w_push    = req_valid && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign req_ready = !w_full;

  assign w_head_dest  = r_mem_dest[r_rd_ptr];
  assign w_head_pair  = r_mem_pair[r_rd_ptr];
  assign w_head_data  = r_mem_data[r_rd_ptr];
  assign w_head_data2 = r_mem_data2[r_rd_ptr];

  assign w_head_in_range = ({27'd0, w_head_dest} < 32'(NUM_DEST));
  assign w_head_onehot   = NUM_DEST'(1) << w_head_dest;

`ifdef R0_WRITE_GUARD_EN
  // R0 is architecturally constant: swallow writes to it silently.
  assign w_head_guarded = (w_head_dest == 5'd0);
`else
  assign w_head_guarded = 1'b0;
`endif

  assign w_head_strobe = w_head_in_range && !w_head_guarded;

  assign load_en   = r_load_en;
  assign load_data = r_load_data;
  assign bad_dest  = r_bad_dest;
  assign bad_code  = r_bad_code;

  // Busy covers queued work, a pending LO half, and the strobe in flight.
  assign busy = !w_empty || (r_state == S_SECOND) || (|r_load_en);

  // FIFO payload write; the pair flag is only kept for HI destinations.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_dest[r_wr_ptr]  <= req_dest;
      r_mem_pair[r_wr_ptr]  <= req_pair && (req_dest == c_dest_hi);
      r_mem_data[r_wr_ptr]  <= req_data;
      r_mem_data2[r_wr_ptr] <= req_data2;
    end
  end

  // FIFO pointers and occupancy count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Load sequencer: one strobe per popped entry, plus the LO half of a pair.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state     <= S_IDLE;
      r_pair_data <= '0;
      r_load_en   <= '0;
      r_load_data <= '0;
      r_bad_dest  <= 1'b0;
      r_bad_code  <= '0;
    end else begin
      r_load_en <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_head_strobe) begin
              r_load_en   <= w_head_onehot;
              r_load_data <= w_head_data;
            end
            // Only the first offending code is remembered until clear.
            if (!w_head_in_range) begin
              r_bad_dest <= 1'b1;
              if (!r_bad_dest) begin
                r_bad_code <= w_head_dest;
              end
            end
            if (w_head_pair) begin
              r_pair_data <= w_head_data2;
              r_state     <= S_SECOND;
            end
          end
        end
        S_SECOND: begin
          r_load_en   <= c_lo_onehot;
          r_load_data <= r_pair_data;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
